repeater_pipe_chain: RTL

REPEATER_PIPE_CHAIN -- requirements
Module: repeater_pipe_chain

---
 rtl/repeater_pipe_pkg.sv | 17 +
 rtl/repeater_slice.sv | 53 +++++
 rtl/repeater_pipe_chain.sv | 102 ++++++++++
 3 files changed

// File: rtl/repeater_pipe_pkg.sv
// Shared constants and helpers for the repeater pipe chain: stage limit,
// control-field width and the depth clamp applied on reconfiguration.
package repeater_pipe_pkg;

  localparam int MAX_STAGES = 16;

  // Width needed to hold any stage count 0..stages.
  function automatic int depth_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Requested depths beyond the built chain saturate at its length.
  function automatic int clamp_depth(input int req, input int stages);
    return (req > stages) ? stages : req;
  endfunction

endpackage

// File: rtl/repeater_slice.sv
// Single-entry register slice with pass-through ready; when bypassed it is a
// wire from upstream to downstream and holds no data.
module repeater_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bypass,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             load;

  assign load = !bypass && in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bypass) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= in_data;
    end
  end

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    in_ready  = !valid_q || out_ready;
    out_valid = valid_q;
    out_data  = data_q;
    if (bypass) begin
      in_ready  = out_ready;
      out_valid = in_valid;
      out_data  = in_data;
    end
  end

endmodule

// File: rtl/repeater_pipe_chain.sv
// Configurable-depth chain of register slices: the first active_depth slices
// register the stream, the rest are bypassed; depth changes only when empty.
module repeater_pipe_chain
  import repeater_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 4,
  localparam int DW     = depth_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DW-1:0]    cfg_depth,
  input  logic             cfg_load,
  output logic             cfg_err,
  output logic [DW-1:0]    active_depth,
  output logic [DW-1:0]    occupancy,
  output logic             idle
);

  logic in_fire;
  logic out_fire;
  logic cfg_ok;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             dn_valid;
    logic             dn_ready;
    logic [WIDTH-1:0] dn_data;
    logic             bypass;

    assign bypass = (DW'(i) >= active_depth);

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = g_stage[i-1].dn_valid;
      assign up_data  = g_stage[i-1].dn_data;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_next
      assign dn_ready = g_stage[i+1].up_ready;
    end

    repeater_slice #(.WIDTH(WIDTH)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .bypass    (bypass),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   (up_data),
      .out_valid (dn_valid),
      .out_ready (dn_ready),
      .out_data  (dn_data)
    );
  end

  // Bypassed tail slices are pure wires, so the outputs are the last active register.
  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[STAGES-1].dn_valid;
  assign out_data  = g_stage[STAGES-1].dn_data;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign idle     = (occupancy == '0);

  // A depth change is only safe with nothing stored and nothing arriving.
  assign cfg_ok = cfg_load && idle && !in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + DW'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_depth <= DW'(STAGES);
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        active_depth <= DW'(clamp_depth(int'(cfg_depth), STAGES));
      end
    end
  end

endmodule
